// File: rtl/cl_divider.sv
// cl_divider: serial integer / carry-less GF(2)[x] divider, one dividend bit per cycle.
// Optional build macro CL_DIV_ZERO_CHECK_EN: a zero divisor skips RUN and flags div_by_zero.
module cl_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    carry_option,
    input  logic [2*DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0]   divisor,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0]   remainder,
    output logic                    div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int QW = 2 * DATA_WIDTH;
    localparam int DW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = $clog2(QW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  pr;
    logic [W-1:0]  pr_n;
    logic [W:0]    t;
    logic [W-1:0]  tl;
    logic [QW-1:0] dq;
    logic [QW-2:0] qw;
    logic [W-1:0]  dv;
    logic [DW-1:0] deg;
    logic [DW-1:0] deg_in;
    logic          mode;
    logic          q_bit;
    logic          last;

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign last = (cnt == CW'(QW - 1));

    always_comb begin
        deg_in = '0;
        for (int i = 0; i < W; i++) begin
            if (divisor[i]) deg_in = DW'(i);
        end
    end

    // t is the shifted window; its top bit only matters for the integer compare
    always_comb begin
        t     = {pr, dq[QW-1]};
        tl    = t[W-1:0];
        pr_n  = tl;
        q_bit = 1'b0;
        if (mode) begin
            if (t >= {1'b0, dv}) begin
                pr_n  = W'(t - {1'b0, dv});
                q_bit = 1'b1;
            end
        end else if (tl[deg]) begin
            pr_n  = tl ^ dv;
            q_bit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pr        <= '0;
            dq        <= '0;
            qw        <= '0;
            dv        <= '0;
            deg       <= '0;
            mode      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    pr  <= pr_n;
                    dq  <= {dq[QW-2:0], 1'b0};
                    qw  <= {qw[QW-3:0], q_bit};
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        quotient  <= {qw, q_bit};
                        remainder <= pr_n;
                    end
                end
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        state <= RUN;
                        mode  <= carry_option;
                        dq    <= dividend;
                        dv    <= divisor;
                        deg   <= deg_in;
                        pr    <= '0;
                        qw    <= '0;
                        cnt   <= '0;
`ifdef CL_DIV_ZERO_CHECK_EN
                        if (divisor == '0) begin
                            state     <= DONE;
                            quotient  <= '1;
                            remainder <= dividend[W-1:0];
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CL_DIV_ZERO_CHECK_EN
    logic dbz;

    always_ff @(posedge clk) begin
        if (rst) begin
            dbz <= 1'b0;
        end else if (state != RUN && start && divisor == '0) begin
            dbz <= 1'b1;
        end else if (state == RUN && last) begin
            dbz <= 1'b0;
        end
    end

    assign div_by_zero = dbz;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_cl_divider.sv
// tb_cl_divider: randomized scoreboard bench for cl_divider at DATA_WIDTH=4.
// Expected results come from plain integer and polynomial long-division models.
module tb_cl_divider;

    localparam int W  = 4;
    localparam int QW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          carry_option = 1'b0;
    logic [QW-1:0] dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic          busy;
    logic          done;
    logic [QW-1:0] quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;

    cl_divider #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .carry_option (carry_option),
        .dividend     (dividend),
        .divisor      (divisor),
        .busy         (busy),
        .done         (done),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [QW-1:0] q;
        logic [W-1:0]  r;
        logic          dbz;
        bit            chk;
        int            due;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int acc_cyc = -1000;
    int busy_len = 0;
    int ready_at = 0;
    logic [QW-1:0] prev_q;
    logic [W-1:0]  prev_r;
    bit eb;
    exp_t me;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    function automatic void cl_ref(input logic [QW-1:0] n, input logic [W-1:0] d,
                                   output logic [QW-1:0] q, output logic [W-1:0] r);
        int dg;
        logic [QW-1:0] rr;
        dg = 0;
        for (int i = 0; i < W; i++) if (d[i]) dg = i;
        rr = n;
        q  = '0;
        for (int i = QW - 1; i >= dg; i--) begin
            if (rr[i]) begin
                rr = rr ^ ({{(QW-W){1'b0}}, d} << (i - dg));
                q[i-dg] = 1'b1;
            end
        end
        r = rr[W-1:0];
    endfunction

    function automatic exp_t ref_model(input logic m, input logic [QW-1:0] n,
                                       input logic [W-1:0] d, input int c);
        exp_t e;
        e.chk = 1'b1;
        e.dbz = 1'b0;
        e.due = c + QW + 1;
        e.q   = '0;
        e.r   = '0;
        if (d == '0) begin
`ifdef CL_DIV_ZERO_CHECK_EN
            e.q   = '1;
            e.r   = n[W-1:0];
            e.dbz = 1'b1;
            e.due = c + 1;
`else
            e.chk = 1'b0;
`endif
        end else if (m) begin
            e.q = n / {{(QW-W){1'b0}}, d};
            e.r = W'(n % {{(QW-W){1'b0}}, d});
        end else begin
            cl_ref(n, d, e.q, e.r);
        end
        return e;
    endfunction

    task automatic wait_ready(input bit junk);
        while (cyc < ready_at) begin
            start        = junk;
            carry_option = 1'($urandom);
            dividend     = QW'($urandom);
            divisor      = W'($urandom);
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic issue(input logic m, input logic [QW-1:0] n,
                         input logic [W-1:0] d, input bit junk);
        exp_t e;
        wait_ready(junk);
        start        = 1'b1;
        carry_option = m;
        dividend     = n;
        divisor      = d;
        e = ref_model(m, n, d, cyc);
        sb.push_back(e);
        acc_cyc  = cyc;
        busy_len = (e.due == cyc + 1) ? 0 : QW;
        ready_at = e.due;
        next_cycle();
        start        = junk;
        carry_option = 1'($urandom);
        dividend     = QW'($urandom);
        divisor      = W'($urandom);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            eb = (cyc > acc_cyc) && (cyc <= acc_cyc + busy_len);
            check("busy", 32'(busy), 32'(eb));
            if (sb.size() > 0 && sb[0].due < cyc) begin
                me = sb.pop_front();
                check("done_missing", cyc, me.due);
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    me = sb.pop_front();
                    check("done_cycle", cyc, me.due);
                    if (me.chk) begin
                        check("quotient", 32'(quotient), 32'(me.q));
                        check("remainder", 32'(remainder), 32'(me.r));
                    end
                    check("div_by_zero", 32'(div_by_zero), 32'(me.dbz));
                end
            end else begin
                check("hold_qr", {quotient, remainder}, {prev_q, prev_r});
            end
        end
        prev_q = quotient;
        prev_r = remainder;
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_quotient"}, 32'(quotient), 32'd0);
        check({tag, "_remainder"}, 32'(remainder), 32'd0);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        int c0;
        next_cycle();
        next_cycle();
        check_zero("reset");
        rst = 1'b0;

        issue(1'b1, 8'h57, 4'hB, 1'b0);
        issue(1'b0, 8'h57, 4'hB, 1'b0);
        issue(1'b0, 8'hC3, 4'h1, 1'b0);
        issue(1'b1, 8'hC3, 4'h1, 1'b0);
        issue(1'b0, 8'h57, 4'h0, 1'b0);
        issue(1'b1, 8'h57, 4'h0, 1'b0);
        wait_ready(1'b0);

        // abort mid-run, then restart two cycles later
        issue(1'b1, 8'hE7, 4'h5, 1'b0);
        c0 = acc_cyc;
        while (cyc < c0 + 4) next_cycle();
        rst = 1'b1;
        sb.delete();
        acc_cyc  = -1000;
        ready_at = 0;
        next_cycle();
        check_zero("abort");
        rst = 1'b0;
        next_cycle();
        issue(1'b0, 8'hE7, 4'h5, 1'b0);

        // start held high across back-to-back operations
        for (int i = 0; i < 6; i++) begin
            issue(1'($urandom), QW'($urandom), W'($urandom_range(1, 15)), 1'b1);
        end
        wait_ready(1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] d;
            bit junk;
            d    = ($urandom_range(0, 7) == 0) ? 4'h0 : W'($urandom_range(1, 15));
            junk = 1'($urandom);
            issue(1'($urandom), QW'($urandom), d, junk);
            if ($urandom_range(0, 3) == 0) begin
                wait_ready(junk);
                repeat ($urandom_range(1, 3)) begin
                    dividend = QW'($urandom);
                    divisor  = W'($urandom);
                    next_cycle();
                end
            end
        end
        wait_ready(1'b0);

        for (int i = 0; i < 50 && sb.size() > 0; i++) next_cycle();
        check("drain", sb.size(), 32'd0);
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cl_divider.md
CL_DIVIDER -- requirements
Module: cl_divider

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the divisor width, with dividend and quotient at 2*DATA_WIDTH.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 carry_option  input  1  1 = integer (carry) division; 0 = carry-less GF(2)[x] division; latched on accepted start.
REQ-006 dividend  input  2*DATA_WIDTH  numerator; latched on accepted start.
REQ-007 divisor  input  DATA_WIDTH  denominator; latched on accepted start.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse when results become valid.
REQ-010 quotient  output  2*DATA_WIDTH  result quotient.
REQ-011 remainder  output  DATA_WIDTH  result remainder.
REQ-012 div_by_zero  output  1  set with done when the latched divisor was 0.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE->RUN on start=1; DONE->RUN on start=1; DONE->IDLE on start=0 after one cycle; RUN->DONE after exactly 2*DATA_WIDTH iterations.
REQ-015 Each RUN cycle SHALL process one dividend bit, MSB first: shift the partial remainder left, shift in the next dividend bit, and form one quotient bit.
REQ-016 Integer mode: if partial remainder >= divisor, subtract the divisor and set the quotient bit to 1; otherwise set it to 0. The partial remainder is DATA_WIDTH+1 bits.
REQ-017 Carry-less mode: deg = index of the divisor MSB, computed once at start; if partial remainder bit [deg] = 1, XOR in the divisor and set the quotient bit to 1; otherwise set it to 0; no carries or borrows.
REQ-018 Latency: start accepted in cycle 0, busy=1 in cycles 1..2*DATA_WIDTH, done=1 in cycle 2*DATA_WIDTH+1.
REQ-019 quotient, remainder and div_by_zero SHALL be valid when done=1 and held unchanged until the next accepted start.
REQ-020 During RUN, quotient and remainder SHALL keep their previous values; internal working registers are separate.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-022 start in the DONE cycle SHALL be accepted: done=1 and busy rises in the next cycle.
REQ-023 Inputs SHALL be ignored except in the cycle a start is accepted.

Reset
REQ-024 rst=1 SHALL force IDLE at the next edge from any state, including mid-RUN, and abandon any operation.
REQ-025 Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-026 The first start SHALL be accepted in the first cycle after rst is released.

Configuration
REQ-027 The macro CL_DIV_ZERO_CHECK_EN SHALL control divide-by-zero handling.
REQ-028 With CL_DIV_ZERO_CHECK_EN defined, a start with divisor=0 SHALL go directly to DONE with done=1 in cycle 1, div_by_zero=1, quotient=all ones, remainder=dividend[DATA_WIDTH-1:0], and busy never asserted.
REQ-029 With CL_DIV_ZERO_CHECK_EN undefined, div_by_zero SHALL be tied to 0, a zero divisor SHALL run the full 2*DATA_WIDTH cycles, and quotient and remainder SHALL be unspecified while done timing is unchanged.

Verification (DATA_WIDTH=4)
REQ-030 Carry-less: carry_option=0, dividend=0x57, divisor=0xB -> done in cycle 9, quotient=0x09, remainder=0x4, div_by_zero=0.
REQ-031 Integer: carry_option=1, dividend=0x57, divisor=0xB -> done in cycle 9, quotient=0x07, remainder=0xA.
REQ-032 Unit divisor in both modes: dividend=0xC3, divisor=0x1 -> quotient=0xC3, remainder=0x0.
REQ-033 Abort: start a division, assert rst in cycle 4 -> busy=0 and done=0 from cycle 5, all outputs 0; a new start in cycle 6 completes correctly in cycle 15.
REQ-034 Busy/back-to-back: start held high throughout -> second and later starts ignored while busy; a new operation begins after each DONE; done pulses exactly every 9 cycles.
REQ-035 Zero divisor with CL_DIV_ZERO_CHECK_EN: divisor=0, dividend=0x57 -> done=1 and div_by_zero=1 in cycle 1, quotient=0xFF, remainder=0x7.
